fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 113 +++++++++++
 tb/tb_fetch_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch-stage PC sequencing: sequential fetch, stall handling, and branch redirects
// that may arrive while an instruction memory access is still outstanding.
module fetch_controller #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            PC_Cur,
  input  logic                   IMem_Ready,
  input  logic                   Stall_F,
  input  logic                   Branch_Taken_E,
  input  logic [31:0]            Branch_Target_E,
  output logic                   PC_En,
  output logic [31:0]            PC_Next,
  output logic                   IMem_Req,
  output logic                   Flush_D,
  output logic                   Redirect_Pending,
  output logic [COUNT_WIDTH-1:0] Fetch_Count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   pending_reg, pending_next;
  logic [31:0]            target_reg, target_next;
  logic [COUNT_WIDTH-1:0] count_reg;

  logic [31:0] branch_aligned;
  logic [31:0] seq_pc;
  logic        unused_bits;

  // Both candidate PCs are forced to word alignment; the dropped low bits are
  // intentionally ignored.
  assign branch_aligned = {Branch_Target_E[31:2], 2'b00};
  assign seq_pc         = {PC_Cur[31:2] + 30'd1, 2'b00};
  assign unused_bits    = ^{PC_Cur[1:0], Branch_Target_E[1:0]};

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    target_next  = target_reg;
    PC_En        = 1'b0;
    PC_Next      = 32'h0000_0000;
    IMem_Req     = 1'b0;
    Flush_D      = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        IMem_Req = 1'b1;
        if (IMem_Ready) begin
          if (pending_reg) begin
            PC_En        = 1'b1;
            PC_Next      = target_reg;
            Flush_D      = 1'b1;
            pending_next = 1'b0;
          end else if (Branch_Taken_E) begin
            PC_En   = 1'b1;
            PC_Next = branch_aligned;
            Flush_D = 1'b1;
          end else if (Stall_F) begin
            state_next = STALL;
          end else begin
            PC_En   = 1'b1;
            PC_Next = seq_pc;
          end
        end else if (Branch_Taken_E && !pending_reg) begin
          // Memory still busy: hold the redirect until the outstanding word returns.
          pending_next = 1'b1;
          target_next  = branch_aligned;
        end
      end
      STALL: begin
        if (Branch_Taken_E) begin
          PC_En      = 1'b1;
          PC_Next    = branch_aligned;
          Flush_D    = 1'b1;
          state_next = FETCH;
        end else if (!Stall_F) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= BOOT;
      pending_reg <= 1'b0;
      target_reg  <= 32'h0000_0000;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      target_reg  <= target_next;
      if (PC_En) begin
        count_reg <= count_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign Redirect_Pending = pending_reg;
  assign Fetch_Count      = count_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, hand-written
// corner sequences and randomized traffic compared against a queue-based model.
module tb_fetch_controller;

  logic        CLK;
  logic        RST;
  logic [31:0] PC_Cur;
  logic        IMem_Ready;
  logic        Stall_F;
  logic        Branch_Taken_E;
  logic [31:0] Branch_Target_E;
  logic        PC_En;
  logic [31:0] PC_Next;
  logic        IMem_Req;
  logic        Flush_D;
  logic        Redirect_Pending;
  logic [31:0] Fetch_Count;

  fetch_controller #(.COUNT_WIDTH(32)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PC_Cur           (PC_Cur),
    .IMem_Ready       (IMem_Ready),
    .Stall_F          (Stall_F),
    .Branch_Taken_E   (Branch_Taken_E),
    .Branch_Target_E  (Branch_Target_E),
    .PC_En            (PC_En),
    .PC_Next          (PC_Next),
    .IMem_Req         (IMem_Req),
    .Flush_D          (Flush_D),
    .Redirect_Pending (Redirect_Pending),
    .Fetch_Count      (Fetch_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: phase flags, a queue holding at most one deferred redirect,
  // and a plain counter of PC loads.
  bit          m_boot;
  bit          m_stall;
  logic [31:0] m_pend_q[$];
  logic [31:0] m_count;

  // Expectations for the current cycle and the effects to apply at the edge.
  logic        e_en, e_req, e_flush, e_pend;
  logic [31:0] e_next;
  bit          go_stall, do_push, do_pop;
  logic [31:0] push_val;

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        en;
    logic [31:0] nxt;
    logic        req;
    logic        flush;
    logic        pend;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_stall = 1'b0;
    m_pend_q.delete();
    m_count = 32'h0;
  endtask

  // Drive one cycle of inputs mid-period, predict outputs, compare before the edge.
  task automatic apply(input logic rdy, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic [31:0] pc);
    @(negedge CLK);
    IMem_Ready      = rdy;
    Stall_F         = stl;
    Branch_Taken_E  = br;
    Branch_Target_E = tgt;
    PC_Cur          = pc;
    #1;
    e_en = 1'b0; e_req = 1'b0; e_flush = 1'b0; e_next = 32'h0;
    do_push = 1'b0; do_pop = 1'b0; push_val = 32'h0;
    go_stall = m_stall;
    e_pend = (m_pend_q.size() != 0);
    if (m_boot) begin
      go_stall = 1'b0;
    end else if (m_stall) begin
      if (br) begin
        e_en = 1'b1; e_flush = 1'b1; e_next = tgt & 32'hFFFF_FFFC; go_stall = 1'b0;
      end else begin
        go_stall = stl;
      end
    end else begin
      e_req = 1'b1;
      if (rdy) begin
        if (m_pend_q.size() != 0) begin
          e_en = 1'b1; e_flush = 1'b1; e_next = m_pend_q[0]; do_pop = 1'b1;
        end else if (br) begin
          e_en = 1'b1; e_flush = 1'b1; e_next = tgt & 32'hFFFF_FFFC;
        end else if (stl) begin
          go_stall = 1'b1;
        end else begin
          e_en = 1'b1; e_next = (pc + 32'd4) & 32'hFFFF_FFFC;
        end
      end else if (br && m_pend_q.size() == 0) begin
        do_push = 1'b1; push_val = tgt & 32'hFFFF_FFFC;
      end
    end
    $display("t=%0t rdy=%b stl=%b br=%b tgt=%h pc=%h -> en=%b next=%h req=%b flush=%b pend=%b cnt=%0d",
             $time, rdy, stl, br, tgt, pc, PC_En, PC_Next, IMem_Req, Flush_D,
             Redirect_Pending, Fetch_Count);
    chk("pc_en", {31'h0, PC_En}, {31'h0, e_en});
    chk("imem_req", {31'h0, IMem_Req}, {31'h0, e_req});
    chk("flush_d", {31'h0, Flush_D}, {31'h0, e_flush});
    chk("redirect_pending", {31'h0, Redirect_Pending}, {31'h0, e_pend});
    chk("fetch_count", Fetch_Count, m_count);
    if (e_en) chk("pc_next", PC_Next, e_next);
  endtask

  task automatic advance();
    @(posedge CLK);
    m_boot  = 1'b0;
    m_stall = go_stall;
    if (do_pop) void'(m_pend_q.pop_front());
    if (do_push) m_pend_q.push_back(push_val);
    if (e_en) m_count = m_count + 32'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_en"}, {31'h0, PC_En}, 32'h0);
    chk({tag, "_imem_req"}, {31'h0, IMem_Req}, 32'h0);
    chk({tag, "_flush_d"}, {31'h0, Flush_D}, 32'h0);
    chk({tag, "_pending"}, {31'h0, Redirect_Pending}, 32'h0);
    chk({tag, "_pc_next"}, PC_Next, 32'h0);
    chk({tag, "_count"}, Fetch_Count, 32'h0);
  endtask

  // Assert reset between edges (asynchronously), confirm outputs drop at once,
  // then release shortly after an edge so the next edge is the BOOT edge.
  task automatic do_reset(input string tag);
    IMem_Ready     = 1'b1;
    Branch_Taken_E = 1'b1;
    Stall_F        = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge CLK);
    #3;
    RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic rdy, input logic stl, input logic br,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic en, input logic [31:0] nxt, input logic req,
                              input logic flush, input logic pend, input logic [31:0] cnt);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.br = br; v.tgt = tgt; v.pc = pc;
    v.en = en; v.nxt = nxt; v.req = req; v.flush = flush; v.pend = pend; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    int n;
    logic [31:0] held_cnt;

    //            rdy stl br  tgt           pc            en  next          req fl  pend cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'd0); // BOOT
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 32'h4,        1, 0, 0, 32'd0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        32'hFFFF_FFFC, 1, 32'h0,       1, 0, 0, 32'd1); // wrap
    vecs[3]  = mk(0, 0, 1, 32'h1003,     32'h0,        0, 32'h0,        1, 0, 0, 32'd2); // capture
    vecs[4]  = mk(0, 0, 1, 32'h2000,     32'h0,        0, 32'h0,        1, 0, 1, 32'd2); // ignored
    vecs[5]  = mk(1, 1, 1, 32'h2000,     32'h0,        1, 32'h1000,     1, 1, 1, 32'd2); // apply
    vecs[6]  = mk(1, 0, 0, 32'h0,        32'h1000,     1, 32'h1004,     1, 0, 0, 32'd3);
    vecs[7]  = mk(1, 1, 0, 32'h0,        32'h1004,     0, 32'h0,        1, 0, 0, 32'd4); // to STALL
    vecs[8]  = mk(1, 1, 0, 32'h0,        32'h1004,     0, 32'h0,        0, 0, 0, 32'd4);
    vecs[9]  = mk(1, 1, 1, 32'h80,       32'h1004,     1, 32'h80,       0, 1, 0, 32'd4); // stall redirect
    vecs[10] = mk(1, 0, 0, 32'h0,        32'h80,       1, 32'h84,       1, 0, 0, 32'd5);
    vecs[11] = mk(1, 1, 1, 32'h303,      32'h84,       1, 32'h300,      1, 1, 0, 32'd6); // branch beats stall
    vecs[12] = mk(1, 1, 0, 32'h0,        32'h300,      0, 32'h0,        1, 0, 0, 32'd7);
    vecs[13] = mk(1, 0, 0, 32'h0,        32'h300,      0, 32'h0,        0, 0, 0, 32'd7); // leave STALL
    vecs[14] = mk(1, 0, 0, 32'h0,        32'h300,      1, 32'h304,      1, 0, 0, 32'd7);

    RST = 1'b1;
    PC_Cur = 32'h0; IMem_Ready = 1'b0; Stall_F = 1'b0;
    Branch_Taken_E = 1'b0; Branch_Target_E = 32'h0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].rdy, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].pc);
      chk($sformatf("vec%0d_en", i), {31'h0, PC_En}, {31'h0, vecs[i].en});
      if (vecs[i].en) chk($sformatf("vec%0d_next", i), PC_Next, vecs[i].nxt);
      chk($sformatf("vec%0d_req", i), {31'h0, IMem_Req}, {31'h0, vecs[i].req});
      chk($sformatf("vec%0d_flush", i), {31'h0, Flush_D}, {31'h0, vecs[i].flush});
      chk($sformatf("vec%0d_pend", i), {31'h0, Redirect_Pending}, {31'h0, vecs[i].pend});
      chk($sformatf("vec%0d_cnt", i), Fetch_Count, vecs[i].cnt);
      advance();
    end

    // Long stall: counter must hold while PC_En stays low.
    apply(1'b1, 1'b1, 1'b0, 32'h0, 32'h304);
    advance();
    held_cnt = m_count;
    n = $urandom_range(10, 4);
    for (int k = 0; k < n; k++) begin
      apply(1'($urandom_range(1, 0)), 1'b1, 1'b0, 32'h0, 32'h304);
      chk("stall_cnt_hold", Fetch_Count, held_cnt);
      advance();
    end
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h304);
    advance();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h400);
    chk("stall_resume_en", {31'h0, PC_En}, 32'h1);
    chk("stall_resume_next", PC_Next, 32'h404);
    advance();

    // Reset while a redirect is pending: it must not survive.
    apply(1'b0, 1'b0, 1'b1, 32'h555, 32'h404);
    advance();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h404);
    do_reset("midreset");
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h10);
    advance();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h10);
    chk("post_reset_next", PC_Next, 32'h14);
    chk("post_reset_flush", {31'h0, Flush_D}, 32'h0);
    advance();

    // Randomized traffic against the model, with one asynchronous reset midway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset("rndreset");
      end
      apply(1'($urandom_range(9, 0) < 7), 1'($urandom_range(3, 0) == 0),
            1'($urandom_range(6, 0) == 0), $urandom, $urandom);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
